// File: rtl/mkmif_pkg.sv
// mkmif_pkg: shared constants and types for the MKM block engine.
// FSM state encoding, word width, default stride, address helper.
package mkmif_pkg;

  localparam int WORD_W          = 32;
  localparam int DEF_ADDR_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Byte address of word idx; wraps modulo 2^16.
  function automatic logic [15:0] word_addr(
    input logic [15:0] base,
    input logic [15:0] idx,
    input logic [15:0] stride
  );
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/mkmif_word_buffer.sv
// mkmif_word_buffer: DEPTH x 32 register array, async clear to zero.
// Ports: one write port (we/waddr/wdata), two comb read ports (a, b).
module mkmif_word_buffer
  import mkmif_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [WORD_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [WORD_W-1:0] rdata_b_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mkmif_block_engine.sv
// mkmif_block_engine: splits a block request into single-word core ops.
// Ports: start/write_mode/base_addr/num_words command, busy/done/error
// status, buf_* host buffer access, core_* op/ready handshake.
// Optional MKMIF_BLOCK_TIMEOUT_EN: per-word watchdog of TIMEOUT_CYCLES.
module mkmif_block_engine
  import mkmif_pkg::*;
#(
  parameter int BUF_DEPTH      = 8,
  parameter int ADDR_STRIDE    = DEF_ADDR_STRIDE,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int AW             = $clog2(BUF_DEPTH),
  parameter int NW             = AW + 1
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              write_mode,
  input  logic [15:0]       base_addr,
  input  logic [NW-1:0]     num_words,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              buf_we,
  input  logic [AW-1:0]     buf_addr,
  input  logic [WORD_W-1:0] buf_wdata,
  output logic [WORD_W-1:0] buf_rdata,
  input  logic              core_ready,
  output logic              core_read_op,
  output logic              core_write_op,
  output logic [15:0]       core_addr,
  output logic [WORD_W-1:0] core_write_data,
  input  logic [WORD_W-1:0] core_read_data
);

  if (BUF_DEPTH < 2 || BUF_DEPTH > 16 || TIMEOUT_CYCLES < 1)
  begin : g_bad_param
    $error("mkmif_block_engine: bad parameter");
  end

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [NW-1:0]     num_q, num_d;
  logic [15:0]       base_q, base_d;
  logic              wmode_q, wmode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rop_q, rop_d;
  logic              wop_q, wop_d;
  logic [15:0]       addr_q, addr_d;
  logic              eng_we, host_we;
  logic              buf_wr;
  logic [AW-1:0]     buf_wa;
  logic [WORD_W-1:0] buf_wd;
  logic              num_ok, last_word;

`ifdef MKMIF_BLOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign num_ok = (num_words != '0) &&
                  (num_words <= NW'(BUF_DEPTH));
  assign last_word = ({1'b0, idx_q} == num_q - 1'b1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    base_d  = base_q;
    wmode_d = wmode_q;
    busy_d  = busy_q;
    err_d   = err_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    rop_d   = 1'b0;
    wop_d   = 1'b0;
    eng_we  = 1'b0;
`ifdef MKMIF_BLOCK_TIMEOUT_EN
    tmo_d   = '0;
`endif
    unique case (state_q)
      // DONE already has busy low, so it takes a start like IDLE.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          if (num_ok) begin
            num_d   = num_words;
            base_d  = base_addr;
            wmode_d = write_mode;
            idx_d   = '0;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (core_ready) begin
          addr_d  = word_addr(base_q, 16'(idx_q),
                              16'(ADDR_STRIDE));
          rop_d   = ~wmode_q;
          wop_d   = wmode_q;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!core_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (core_ready) begin
          eng_we = ~wmode_q;
          if (last_word) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
`ifdef MKMIF_BLOCK_TIMEOUT_EN
    // Counts cycles spent waiting on one word; restarts per op.
    if ((state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE) &&
        (state_d == ST_WAIT_ACK || state_d == ST_WAIT_DONE)) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      base_q  <= '0;
      wmode_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rop_q   <= 1'b0;
      wop_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      base_q  <= base_d;
      wmode_q <= wmode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rop_q   <= rop_d;
      wop_q   <= wop_d;
      addr_q  <= addr_d;
    end
  end

`ifdef MKMIF_BLOCK_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // Host writes are locked out while a transfer owns the buffer.
  assign host_we = buf_we & ~busy_q;
  assign buf_wr  = host_we | eng_we;
  assign buf_wa  = eng_we ? idx_q : buf_addr;
  assign buf_wd  = eng_we ? core_read_data : buf_wdata;

  mkmif_word_buffer #(
    .DEPTH (BUF_DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .we_i      (buf_wr),
    .waddr_i   (buf_wa),
    .wdata_i   (buf_wd),
    .raddr_a_i (buf_addr),
    .rdata_a_o (buf_rdata),
    .raddr_b_i (idx_q),
    .rdata_b_o (core_write_data)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign core_read_op  = rop_q;
  assign core_write_op = wop_q;
  assign core_addr     = addr_q;

endmodule

// File: doc/mkmif_block_engine.md
# mkmif_block_engine

Multi-word transfer sequencer sitting directly upstream of the MKM interface core. It accepts one block request (base address, word count, direction) and breaks it into single 32-bit read or write operations on the core's op/ready handshake. It stages the data in a local word buffer that the host API reads and writes. The host therefore moves a whole key (up to 8 words) with one command instead of polling the core per word.

## Interface
- BUF_DEPTH, 8: buffer depth in 32-bit words (power of two, 2..16).
- ADDR_STRIDE, 4: byte increment of the memory address between consecutive words.
- TIMEOUT_CYCLES, 65535: watchdog limit in cycles per word (used only with the timeout feature).
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  single-cycle command strobe; accepted only when busy=0.
- write_mode  in  1  1 = buffer-to-memory, 0 = memory-to-buffer; sampled with start.
- base_addr  in  16  memory byte address of word 0; sampled with start.
- num_words  in  $clog2(BUF_DEPTH)+1  words to transfer, valid range 1..BUF_DEPTH; sampled with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end (success or error).
- error  out  1  sticky status of the last command; cleared by the next accepted start.
- buf_we  in  1  host buffer write; ignored while busy.
- buf_addr  in  $clog2(BUF_DEPTH)  host buffer index.
- buf_wdata  in  32  host write data.
- buf_rdata  out  32  buffer[buf_addr], combinational read.
- core_ready  in  1  core ready.
- core_read_op, core_write_op  out  1  registered single-cycle op strobes.
- core_addr  out  16  word address to core; held stable from the op strobe until core_ready returns.
- core_write_data  out  32  buffer[word index]; held stable like core_addr.
- core_read_data  in  32  core read result.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE.
- IDLE:
  - start with num_words in 1..BUF_DEPTH: latch the parameters, set idx=0, set busy=1, clear error, go to ISSUE.
  - start with num_words=0 or num_words>BUF_DEPTH: set error=1, pulse done, stay IDLE; no core op is issued.
- ISSUE: wait for core_ready=1. Then assert the op matching write_mode for exactly one cycle and go to WAIT_ACK.
- WAIT_ACK: wait for core_ready=0 (the core has accepted the op), then go to WAIT_DONE.
- WAIT_DONE: wait for core_ready=1.
  - On read, write core_read_data into buffer[idx] that cycle.
  - If idx=num_words-1, go to DONE; otherwise increment idx and go to ISSUE.
- DONE: pulse done, clear busy, go to IDLE.
- Address: core_addr = base_addr + idx*ADDR_STRIDE, computed in 16 bits and wrapping modulo 2^16 (0xFFFC + 4 → 0x0000).
- Ignored inputs:
  - start while busy is ignored.
  - buf_we while busy is ignored, so the buffer cannot be corrupted mid-transfer.
- Simultaneous events: start and buf_we in the same IDLE cycle → the buffer write lands first and is included in a write transfer.
- Reset mid-transfer: all state returns to IDLE and the op strobes drop immediately. Buffer contents are cleared to zero.
- Reset values: busy=0, done=0, error=0, core_read_op=0, core_write_op=0, core_addr=0, buffer all 0, buf_rdata=0.

## Timing
- Start to first op strobe: 1 cycle if core_ready=1 at start (IDLE→ISSUE at edge 1, strobe registered at edge 2).
- Per-word overhead is 3 cycles of local FSM plus the core's own SPI time.
- done follows the final core_ready rise by exactly 1 cycle; busy falls on the same edge as done.
- Only one op is ever outstanding; never two strobes without an intervening core_ready low→high.

## Configuration
- MKMIF_BLOCK_TIMEOUT_EN defined:
  - A per-word counter runs in WAIT_ACK and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES sets error=1 and forces DONE (done pulses, busy clears).
  - Buffer words already transferred remain valid.
- Not defined: no counter exists, and the engine waits indefinitely on core_ready.

## Structure
- Shared package mkmif_pkg: the FSM state encoding constants, the default ADDR_STRIDE, and the word width constant (32).
- Sub-module mkmif_word_buffer: the BUF_DEPTH×32 register array, with one write port (muxed host/engine) and two combinational read ports (host, core_write_data).

## Test plan
- Read of 4 words at base 0x0100; model core returns 0x11111111..0x44444444 → ops issued at addresses 0x0100, 0x0104, 0x0108, 0x010C; buf_rdata[0..3] = the returned values; one done pulse, error=0.
- Host writes 0xDEADBEEF, 0xCAFEBABE into buffer[0..1], then a 2-word write at base 0xFFFC → core_write_op issued with addr 0xFFFC/data 0xDEADBEEF, then addr 0x0000/data 0xCAFEBABE.
- start with num_words=0 → done pulse 1 cycle later, error=1, no core op strobe; the next valid start clears error.
- Second start and buf_we pulsed while busy → both ignored; transfer count and buffer contents unchanged.
- reset_n low during WAIT_DONE of word 2 → busy=0, strobes=0, buffer all 0 immediately; a later start runs normally.
- With MKMIF_BLOCK_TIMEOUT_EN and TIMEOUT_CYCLES=16, core_ready held low → error=1 and a done pulse 16 cycles after the ack; without the macro, busy stays 1.
